m3_six_step_commutator: RTL and testbench



---
 rtl/m3_six_step_commutator.sv | 173 +++++++++++++++++
 tb/tb_m3_six_step_commutator.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/m3_six_step_commutator.sv
// Six-step commutation generator for the M3 three-phase bridge: programmable
// step period (word x prescaler), run-time direction and per-phase dead-time.
module m3_six_step_commutator #(
    parameter int FREQ_W   = 10,
    parameter int PRE_DIV  = 16,
    parameter int DEAD_CYC = 8,
    parameter int DT_W     = 4
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              m3start,
    input  logic              m3dir,
    input  logic [FREQ_W-1:0] m3freq,
    output logic              aH,
    output logic              aL,
    output logic              bH,
    output logic              bL,
    output logic              cH,
    output logic              cL,
    output logic [2:0]        m3step,
    output logic              m3run,
    output logic              stepPulse
);
    localparam int PRE_W = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
    localparam logic [1:0] TGT_Z = 2'd0;
    localparam logic [1:0] TGT_H = 2'd1;
    localparam logic [1:0] TGT_L = 2'd2;

    typedef enum logic {IDLE, RUN} state_t;

    // Phase targets packed as {C, B, A}, two bits each.
    function automatic logic [5:0] step_targets(input logic [2:0] s);
        logic [5:0] t;
        t = {TGT_Z, TGT_Z, TGT_Z};
        case (s)
            3'd0: t = {TGT_Z, TGT_L, TGT_H};
            3'd1: t = {TGT_L, TGT_Z, TGT_H};
            3'd2: t = {TGT_L, TGT_H, TGT_Z};
            3'd3: t = {TGT_Z, TGT_H, TGT_L};
            3'd4: t = {TGT_H, TGT_Z, TGT_L};
            3'd5: t = {TGT_H, TGT_L, TGT_Z};
            default: t = {TGT_Z, TGT_Z, TGT_Z};
        endcase
        return t;
    endfunction

    state_t            state_reg, state_next;
    logic [2:0]        step_reg, step_next, step_adv;
    logic [FREQ_W-1:0] freq_reg, freq_next;
    logic [FREQ_W-1:0] per_reg, per_next;
    logic [PRE_W-1:0]  pre_reg, pre_next;
    logic              pulse_reg, pulse_next;
    logic [5:0]        tgt_reg, tgt_next;
    logic              tick;
    logic [2:0]        gate_h, gate_l;

    assign tick     = (pre_reg == PRE_W'(PRE_DIV - 1));
    assign step_adv = m3dir ? ((step_reg == 3'd0) ? 3'd5 : step_reg - 3'd1)
                            : ((step_reg == 3'd5) ? 3'd0 : step_reg + 3'd1);

    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        freq_next  = freq_reg;
        per_next   = per_reg;
        pre_next   = pre_reg;
        pulse_next = 1'b0;
        tgt_next   = tgt_reg;
        case (state_reg)
            IDLE: begin
                tgt_next = '0;
                if (m3start) begin
                    state_next = RUN;
                    freq_next  = m3freq;
                    per_next   = '0;
                    pre_next   = '0;
                    tgt_next   = step_targets(step_reg);
                end
            end
            RUN: begin
                // Stop wins over a coinciding advance.
                if (!m3start) begin
                    state_next = IDLE;
                    step_next  = '0;
                    per_next   = '0;
                    pre_next   = '0;
                    tgt_next   = '0;
                end else begin
                    pre_next = tick ? '0 : pre_reg + PRE_W'(1);
                    if (tick) begin
                        if (freq_reg == '0) begin
                            freq_next = m3freq;
                        end else if (per_reg == freq_reg - FREQ_W'(1)) begin
                            step_next  = step_adv;
                            per_next   = '0;
                            freq_next  = m3freq;
                            pulse_next = 1'b1;
                            tgt_next   = step_targets(step_adv);
                        end else begin
                            per_next = per_reg + FREQ_W'(1);
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_reg <= IDLE;
            step_reg  <= '0;
            freq_reg  <= '0;
            per_reg   <= '0;
            pre_reg   <= '0;
            pulse_reg <= 1'b0;
            tgt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
            freq_reg  <= freq_next;
            per_reg   <= per_next;
            pre_reg   <= pre_next;
            pulse_reg <= pulse_next;
            tgt_reg   <= tgt_next;
        end
    end

    // Per-phase interlock: any target change blanks both switches; a new
    // H/L target waits DEAD_CYC edges before its switch is driven.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_phase
            logic [DT_W-1:0] dt_reg;
            logic            h_reg, l_reg;
            logic [1:0]      tgt_cur, tgt_new;

            assign tgt_cur = tgt_reg[2*gi +: 2];
            assign tgt_new = tgt_next[2*gi +: 2];

            always_ff @(posedge clk or negedge nRst) begin
                if (!nRst) begin
                    dt_reg <= '0;
                    h_reg  <= 1'b0;
                    l_reg  <= 1'b0;
                end else if (tgt_new != tgt_cur) begin
                    h_reg  <= 1'b0;
                    l_reg  <= 1'b0;
                    dt_reg <= (tgt_new == TGT_Z) ? '0 : DT_W'(DEAD_CYC - 1);
                end else if (dt_reg != '0) begin
                    h_reg  <= 1'b0;
                    l_reg  <= 1'b0;
                    dt_reg <= dt_reg - DT_W'(1);
                end else begin
                    h_reg <= (tgt_cur == TGT_H);
                    l_reg <= (tgt_cur == TGT_L);
                end
            end

            assign gate_h[gi] = h_reg;
            assign gate_l[gi] = l_reg;
        end
    endgenerate

    assign aH        = gate_h[0];
    assign aL        = gate_l[0];
    assign bH        = gate_h[1];
    assign bL        = gate_l[1];
    assign cH        = gate_h[2];
    assign cL        = gate_l[2];
    assign m3step    = step_reg;
    assign m3run     = (state_reg == RUN);
    assign stepPulse = pulse_reg;
endmodule

// File: tb/tb_m3_six_step_commutator.sv
// Randomised bench for m3_six_step_commutator against a timestamp-based
// reference model of step timing, commutation table and dead-time.
module tb_m3_six_step_commutator;
    localparam int FREQ_W   = 10;
    localparam int PRE_DIV  = 2;
    localparam int DEAD_CYC = 3;
    localparam int DT_W     = 4;

    logic              clk = 1'b0;
    logic              nRst = 1'b1;
    logic              m3start = 1'b0;
    logic              m3dir = 1'b0;
    logic [FREQ_W-1:0] m3freq = '0;
    logic              aH, aL, bH, bL, cH, cL;
    logic [2:0]        m3step;
    logic              m3run;
    logic              stepPulse;

    int checks = 0;
    int errors = 0;

    m3_six_step_commutator #(
        .FREQ_W  (FREQ_W),
        .PRE_DIV (PRE_DIV),
        .DEAD_CYC(DEAD_CYC),
        .DT_W    (DT_W)
    ) dut (
        .clk      (clk),
        .nRst     (nRst),
        .m3start  (m3start),
        .m3dir    (m3dir),
        .m3freq   (m3freq),
        .aH       (aH),
        .aL       (aL),
        .bH       (bH),
        .bL       (bL),
        .cH       (cH),
        .cL       (cL),
        .m3step   (m3step),
        .m3run    (m3run),
        .stepPulse(stepPulse)
    );

    always #5 clk = ~clk;

    // Reference model: edge counter plus timestamps of run entry, period
    // latch and each phase's last target change.
    string tbl [6] = '{"HLZ", "HZL", "ZHL", "LHZ", "LZH", "ZLH"};
    int  t;
    bit  m_run;
    int  m_step;
    int  m_freq;
    int  m_latch;
    int  m_entry;
    bit  m_pulse;
    byte m_tgt [3];
    int  m_chg [3];
    int  pulse_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h required=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_step  = 0;
        m_freq  = 0;
        m_pulse = 1'b0;
        for (int p = 0; p < 3; p++) begin
            m_tgt[p] = "Z";
            m_chg[p] = 0;
        end
    endtask

    task automatic model_edge();
        byte nt [3];
        t++;
        if (!nRst) begin
            model_reset();
            return;
        end
        m_pulse = 1'b0;
        for (int p = 0; p < 3; p++) nt[p] = m_tgt[p];
        if (!m_run) begin
            for (int p = 0; p < 3; p++) nt[p] = "Z";
            if (m3start) begin
                m_run   = 1'b1;
                m_entry = t;
                m_latch = t;
                m_freq  = int'(m3freq);
                for (int p = 0; p < 3; p++) nt[p] = tbl[m_step][p];
            end
        end else if (!m3start) begin
            m_run  = 1'b0;
            m_step = 0;
            for (int p = 0; p < 3; p++) nt[p] = "Z";
        end else if (m_freq == 0) begin
            if ((t - m_entry) % PRE_DIV == 0) begin
                m_freq  = int'(m3freq);
                m_latch = t;
            end
        end else if (t - m_latch == m_freq * PRE_DIV) begin
            m_step  = m3dir ? (m_step + 5) % 6 : (m_step + 1) % 6;
            m_freq  = int'(m3freq);
            m_latch = t;
            m_pulse = 1'b1;
            for (int p = 0; p < 3; p++) nt[p] = tbl[m_step][p];
        end
        for (int p = 0; p < 3; p++) begin
            if (nt[p] != m_tgt[p]) begin
                m_tgt[p] = nt[p];
                m_chg[p] = t;
            end
        end
    endtask

    task automatic compare_all();
        logic [5:0] eg;
        eg = '0;
        for (int p = 0; p < 3; p++) begin
            if (m_tgt[p] != "Z" && (t - m_chg[p]) >= DEAD_CYC) begin
                if (m_tgt[p] == "H") eg[5 - 2*p] = 1'b1;
                else                 eg[4 - 2*p] = 1'b1;
            end
        end
        chk("step",  32'(m3step), 32'(m_step));
        chk("run",   32'(m3run), 32'(m_run));
        chk("pulse", 32'(stepPulse), 32'(m_pulse));
        chk("gates", 32'({aH, aL, bH, bL, cH, cL}), 32'(eg));
        if (stepPulse) begin
            pulse_cnt++;
            $display("t=%0t step advance -> %0d (dir=%0b)", $time, m3step, m3dir);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    always @(negedge clk) begin
        checks++;
        assert (!((aH && aL) || (bH && bL) || (cH && cL)))
        else begin
            errors++;
            $display("FAIL shoot_through: got=%b%b%b%b%b%b required=no H/L pair both high",
                     aH, aL, bH, bL, cH, cL);
        end
    end

    initial begin
        int  p0, lat, s0;
        bit  found;
        t = 0;
        model_reset();
        #1 nRst = 1'b0;
        repeat (3) cycle();
        nRst = 1'b1;

        // Forward run: period 10, seven advances in 72 edges.
        m3freq = 10'd5; m3dir = 1'b0; m3start = 1'b1;
        p0 = pulse_cnt;
        repeat (72) cycle();
        chk("fwd_pulses", 32'(pulse_cnt - p0), 32'd7);
        chk("fwd_step", 32'(m3step), 32'd1);
        m3start = 1'b0;
        repeat (3) cycle();

        // Reverse run.
        m3dir = 1'b1; m3start = 1'b1;
        p0 = pulse_cnt;
        repeat (72) cycle();
        chk("rev_pulses", 32'(pulse_cnt - p0), 32'd7);
        chk("rev_step", 32'(m3step), 32'd5);
        m3start = 1'b0;
        repeat (3) cycle();

        // Random direction, period and stop/start traffic.
        for (int i = 0; i < 400; i++) begin
            if (i % 7 == 0) m3freq = FREQ_W'($urandom_range(0, 4));
            m3dir   = 1'($urandom_range(0, 1));
            m3start = ($urandom_range(0, 39) != 0);
            cycle();
        end

        // Hold with period word 0, then restart at 3.
        m3start = 1'b1; m3dir = 1'b0; m3freq = 10'd2;
        repeat (20) cycle();
        m3freq = '0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            found = m_run && (m_freq == 0);
        end
        chk("hold_latch_timeout", 32'(found), 32'd1);
        s0 = m_step;
        p0 = pulse_cnt;
        repeat (50) cycle();
        chk("hold_step", 32'(m3step), 32'(s0));
        chk("hold_pulses", 32'(pulse_cnt - p0), 32'd0);
        m3freq = 10'd3;
        p0 = pulse_cnt;
        lat = 0;
        for (int i = 0; i < 20 && pulse_cnt == p0; i++) begin
            cycle();
            lat++;
        end
        chk("restart_within_8", 32'(lat >= 1 && lat <= 8), 32'd1);
        p0 = pulse_cnt;
        lat = 0;
        for (int i = 0; i < 20 && pulse_cnt == p0; i++) begin
            cycle();
            lat++;
        end
        chk("restart_period", 32'(lat), 32'd6);

        // Stop on the very edge of an advance.
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_run && m_freq != 0 && (t + 1 - m_latch) == m_freq * PRE_DIV) found = 1'b1;
            else cycle();
        end
        chk("adv_search_timeout", 32'(found), 32'd1);
        m3start = 1'b0;
        cycle();
        chk("stop_pulse", 32'(stepPulse), 32'd0);
        chk("stop_step", 32'(m3step), 32'd0);
        chk("stop_run", 32'(m3run), 32'd0);
        chk("stop_gates", 32'({aH, aL, bH, bL, cH, cL}), 32'd0);
        repeat (2) cycle();

        // Asynchronous reset in the middle of a dead-time window.
        m3freq = 10'd5; m3dir = 1'b0; m3start = 1'b1;
        repeat (2) cycle();
        @(posedge clk);
        t++;
        #2 nRst = 1'b0;
        #1;
        chk("rst_async_gates", 32'({aH, aL, bH, bL, cH, cL}), 32'd0);
        chk("rst_async_step", 32'(m3step), 32'd0);
        chk("rst_async_run", 32'(m3run), 32'd0);
        chk("rst_async_pulse", 32'(stepPulse), 32'd0);
        model_reset();
        @(negedge clk);
        repeat (2) cycle();
        nRst = 1'b1;
        cycle();
        chk("rst_entry_gates", 32'({aH, aL, bH, bL, cH, cL}), 32'd0);
        chk("rst_entry_run", 32'(m3run), 32'd1);
        repeat (2) cycle();
        chk("rst_dead_off", 32'({aH, aL, bH, bL, cH, cL}), 32'd0);
        cycle();
        chk("rst_dead_on", 32'({aH, aL, bH, bL, cH, cL}), 32'b100100);
        repeat (12) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
